rc4_stream_cipher: RTL and testbench

- Byte-wide RC4 encryption engine with an on-chip ciphertext buffer.
- After reset it builds the RC4 state from an 8-bit password, then runs the key-scheduling algorithm (KSA).
- It then generates keystream continuously into a prefetch FIFO, XORs plaintext bytes strobed in by valid1, and queues the ciphertext.
- A downstream consumer drains the ciphertext with valid. Sits between a plaintext byte source and a link/transmit stage.

---
 rtl/rc4_stream_cipher.sv | 156 +++++++++++++++
 tb/tb_rc4_stream_cipher.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_cipher.sv
// RC4 byte encryptor: INIT + KSA setup (768 cycles, 1536 with RC4_DROP256_EN), keystream prefetch FIFO, ciphertext FIFO.
// data_out is registered one cycle after a valid pop; plaintext is dropped unless in PRGA with keystream ready and ciphertext space.
module rc4_stream_cipher #(
    parameter int KS_DEPTH = 16,
    parameter int CT_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] password,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       valid1,
    input  logic       valid
);
    localparam int KAW = $clog2(KS_DEPTH);
    localparam int CAW = $clog2(CT_DEPTH);
    localparam logic [KAW:0] KS_FULL = KS_DEPTH[KAW:0];
    localparam logic [CAW:0] CT_FULL = CT_DEPTH[CAW:0];

    typedef enum logic [1:0] {INIT, KSA, DROP, PRGA} state_t;
    state_t state, state_nxt;

    logic [7:0] s_mem [256];
    logic [7:0] i, j, key_q, drop_cnt;
    logic [1:0] phase;
    logic [7:0] si, sj, t, ks_byte;
    logic       gen_step, ks_push, enc_acc, ct_pop;

    logic [7:0]     ks_mem [KS_DEPTH];
    logic [KAW-1:0] ks_wr, ks_rd;
    logic [KAW:0]   ks_cnt;
    logic           ks_full, ks_empty;

    logic [7:0]     ct_mem [CT_DEPTH];
    logic [CAW-1:0] ct_wr, ct_rd;
    logic [CAW:0]   ct_cnt;
    logic           ct_full, ct_empty;

    assign si = s_mem[i];
    assign sj = s_mem[j];
    assign t  = si + sj;
    // Output byte is read from the post-swap state: S[i] and S[j] have exchanged values.
    assign ks_byte = (t == i) ? sj : (t == j) ? si : s_mem[t];

    assign ks_full  = (ks_cnt == KS_FULL);
    assign ks_empty = (ks_cnt == '0);
    assign ct_full  = (ct_cnt == CT_FULL);
    assign ct_empty = (ct_cnt == '0);

    // A step only starts when there is room; once started it always completes.
    assign gen_step = (state == DROP) || ((state == PRGA) && ((phase != 2'd0) || !ks_full));
    assign ks_push  = (state == PRGA) && (phase == 2'd2);
    assign enc_acc  = valid1 && (state == PRGA) && !ks_empty && !ct_full;
    assign ct_pop   = valid && !ct_empty;

    always_ff @(posedge clk) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (i == 8'hff) state_nxt = KSA;
            KSA: begin
                if (phase[0] && (i == 8'hff)) begin
`ifdef RC4_DROP256_EN
                    state_nxt = DROP;
`else
                    state_nxt = PRGA;
`endif
                end
            end
            DROP: if ((phase == 2'd2) && (drop_cnt == 8'hff)) state_nxt = PRGA;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            i        <= 8'h00;
            j        <= 8'h00;
            key_q    <= 8'h00;
            phase    <= 2'd0;
            drop_cnt <= 8'h00;
        end else begin
            case (state)
                INIT: begin
                    if (i == 8'h00) key_q <= password;
                    i <= i + 8'd1;
                end
                KSA: begin
                    phase <= phase[0] ? 2'd0 : 2'd1;
                    if (!phase[0]) begin
                        j <= j + si + key_q;
                    end else begin
                        i <= i + 8'd1;
                        if (i == 8'hff) j <= 8'h00;
                    end
                end
                default: begin
                    if (gen_step) begin
                        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                        case (phase)
                            2'd0:    i <= i + 8'd1;
                            2'd1:    j <= j + si;
                            default: if (state == DROP) drop_cnt <= drop_cnt + 8'd1;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == INIT) begin
                s_mem[i] <= i;
            end else if ((state == KSA && phase[0]) || (gen_step && phase == 2'd2)) begin
                s_mem[i] <= sj;
                s_mem[j] <= si;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ks_wr    <= '0;
            ks_rd    <= '0;
            ks_cnt   <= '0;
            ct_wr    <= '0;
            ct_rd    <= '0;
            ct_cnt   <= '0;
            data_out <= 8'h00;
        end else begin
            if (ks_push) begin
                ks_mem[ks_wr] <= ks_byte;
                ks_wr         <= ks_wr + 1'b1;
            end
            if (enc_acc) begin
                ks_rd         <= ks_rd + 1'b1;
                ct_mem[ct_wr] <= data_in ^ ks_mem[ks_rd];
                ct_wr         <= ct_wr + 1'b1;
            end
            if (ks_push && !enc_acc)      ks_cnt <= ks_cnt + 1'b1;
            else if (!ks_push && enc_acc) ks_cnt <= ks_cnt - 1'b1;

            if (ct_pop) begin
                data_out <= ct_mem[ct_rd];
                ct_rd    <= ct_rd + 1'b1;
            end
            if (enc_acc && !ct_pop)      ct_cnt <= ct_cnt + 1'b1;
            else if (!enc_acc && ct_pop) ct_cnt <= ct_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Self-checking bench for rc4_stream_cipher: software RC4 model plus a ciphertext scoreboard queue.
module tb_rc4_stream_cipher;
    localparam int KS_N = 1024;
`ifdef RC4_DROP256_EN
    localparam int KS_OFF = 256;
    localparam int SETUP  = 1536;
`else
    localparam int KS_OFF = 0;
    localparam int SETUP  = 768;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] password;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid1;
    logic       valid;

    rc4_stream_cipher #(.KS_DEPTH(16), .CT_DEPTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .password (password),
        .data_in  (data_in),
        .data_out (data_out),
        .valid1   (valid1),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pt;
        logic       acc;
    } vec_t;

    logic [7:0] ks_tab [KS_N];
    logic [7:0] exp_q [$];
    logic [7:0] last_out;
    int         kidx;
    int         n_chk;
    int         n_fail;
    vec_t       burst_tab [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic gen_ks(input logic [7:0] key);
        logic [7:0] s [256];
        logic [7:0] a, b, tmp;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        b = 8'h00;
        for (int n = 0; n < 256; n++) begin
            b = b + s[n] + key;
            tmp = s[n]; s[n] = s[b]; s[b] = tmp;
        end
        a = 8'h00;
        b = 8'h00;
        for (int n = 0; n < KS_N; n++) begin
            a = a + 8'd1;
            b = b + s[a];
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            tmp = s[a] + s[b];
            ks_tab[n] = s[tmp];
        end
    endtask

    // One clock: acc says whether the bench expects this plaintext byte to be accepted.
    task automatic cyc(input string name, input logic v1, input logic [7:0] d,
                       input logic acc, input logic v);
        logic       do_pop;
        logic [7:0] e;
        do_pop = v && (exp_q.size() != 0);
        if (v1 && acc) begin
            exp_q.push_back(d ^ ks_tab[kidx]);
            kidx++;
        end
        valid1  = v1;
        data_in = d;
        valid   = v;
        @(posedge clk);
        #1;
        if (do_pop) begin
            e = exp_q.pop_front();
            last_out = e;
            check(name, data_out, e);
        end else if (v) begin
            check({name, "_hold"}, data_out, last_out);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name, input int n);
        for (int k = 0; k < n; k++) cyc(name, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input logic [7:0] pw);
        valid1   = 1'b0;
        valid    = 1'b0;
        data_in  = 8'h00;
        rst      = 1'b0;
        password = pw;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", data_out, 8'h00);
        exp_q.delete();
        last_out = 8'h00;
        gen_ks(pw);
        kidx = KS_OFF;
        rst  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        password = 8'h00;
        data_in  = 8'h00;
        valid1   = 1'b0;
        valid    = 1'b0;
        last_out = 8'h00;
        kidx     = 0;

        burst_tab[0] = '{8'd5,  1'b1};
        burst_tab[1] = '{8'd10, 1'b1};
        burst_tab[2] = '{8'd20, 1'b1};
        burst_tab[3] = '{8'd30, 1'b1};
        for (int k = 4; k < 9; k++) burst_tab[k] = '{8'd40, 1'b1};

        // Setup with key 0x01; strobes during INIT/KSA must vanish, later password edits are ignored.
        do_reset(8'h01);
        cyc("setup", 1'b0, 8'h00, 1'b0, 1'b0);
        password = 8'hff;
        for (int c = 2; c <= SETUP + 2; c++) begin
            if (c == 10 || c == 400 || c == SETUP - 1)
                cyc("setup_drop", 1'b1, 8'h5a, 1'b0, 1'b1);
            else
                cyc("setup", 1'b0, 8'h00, 1'b0, 1'b0);
        end
        // First keystream byte lands three cycles after setup; the strobe one edge earlier is dropped.
        cyc("first_drop", 1'b1, 8'h11, 1'b0, 1'b0);
        cyc("first_acc",  1'b1, 8'h22, 1'b1, 1'b0);
        idle(78);
        for (int k = 0; k < 5; k++) cyc("ks", 1'b1, 8'h00, 1'b1, 1'b0);
        drain("ks_out", 8);

        idle(60);
        for (int k = 0; k < 9; k++) cyc("burst", 1'b1, burst_tab[k].pt, burst_tab[k].acc, 1'b0);
        drain("burst_out", 16);

        // Fill ciphertext to 28 slowly, then a 40-cycle burst: only 4 fit.
        idle(60);
        for (int b = 0; b < 28; b++) begin
            cyc("ovf_fill", 1'b1, 8'(b), 1'b1, 1'b0);
            idle(3);
        end
        idle(60);
        for (int b = 0; b < 40; b++) cyc("ovf_burst", 1'b1, 8'(8'h80 + b), (b < 4), 1'b0);
        drain("ovf_out", 40);

        idle(60);
        for (int b = 0; b < 3; b++) begin
            cyc("conc_fill", 1'b1, 8'(8'hc0 + b), 1'b1, 1'b0);
            idle(3);
        end
        idle(40);
        for (int b = 0; b < 20; b++) cyc("conc", 1'b1, 8'(8'h40 + b), 1'b1, 1'b1);
        drain("conc_out", 6);

        // Reset with ciphertext queued, then again in the middle of KSA.
        idle(60);
        for (int b = 0; b < 4; b++) cyc("pre_rst", 1'b1, 8'(b + 1), 1'b1, 1'b0);
        do_reset(8'h02);
        idle(300);
        do_reset(8'h02);
        idle(SETUP + 60);
        drain("post_rst_empty", 3);
        for (int b = 0; b < 6; b++) cyc("key2", 1'b1, 8'(b * 17), 1'b1, 1'b0);
        drain("key2_out", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
